keypad_emulator: RTL and testbench

- Responder end of the 4x4 matrix keypad interface; used on the bench and in self-test builds in place of the physical keypad.
- keypad_scan drives active-low rows and samples active-low columns. This block models the switch matrix: a host queues key-press commands, and the block answers the row scan on col_n with realistic press, bounce, hold and release timing.

---
 rtl/keypad_emulator.sv | 190 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
//
// Stands in for a physical 4x4 matrix keypad on the bench and in self-test
// builds. A host queues one key press at a time; the block then plays back
// press bounce, a solid hold, release bounce and a quiet gap. While the
// contact is closed it answers the scanner's active-low row drive on the
// matching active-low column line.
//
// Parameters:
//   BOUNCE_PERIOD - clk cycles per bounce phase (>= 1)
//   GAP_CYCLES    - clk cycles of open contact after release (>= 1)
//   HOLD_W        - width of the hold-duration field
//
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   row_n      - row drive from the scanner, row i active when row_n[i]=0
//   col_n      - column return, active-low, idle 4'b1111
//   cmd_valid  - host command valid
//   cmd_ready  - block is idle and can accept a command
//   cmd_key    - key code, [3:2] row index, [1:0] column index
//   cmd_hold   - cycles of solid closure (0 behaves as 1)
//   cmd_bounce - bounce count N on press and on release (0 = clean edges)
//   abort      - cancel the current press
//   key_down   - current contact state (1 = closed)
//   active_key - key code latched when the command was accepted
//   busy       - a command is in progress
//   done       - one-cycle pulse when a command completes normally
// ---------------------------------------------------------------------------
module keypad_emulator #(
    parameter int BOUNCE_PERIOD = 4,
    parameter int GAP_CYCLES    = 8,
    parameter int HOLD_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        row_n,
    output logic [3:0]        col_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        cmd_bounce,
    input  logic              abort,
    output logic              key_down,
    output logic [3:0]        active_key,
    output logic              busy,
    output logic              done
);

    // One shared down-counter times every phase, so it must be wide enough
    // for the longest of a bounce phase, the hold and the gap.
    localparam int BP_W  = $clog2(BOUNCE_PERIOD + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_A = (HOLD_W > BP_W) ? HOLD_W : BP_W;
    localparam int CNT_W = (CNT_A > GAP_W) ? CNT_A : GAP_W;

    localparam logic [CNT_W-1:0] BP_LOAD  = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HELD,
        S_BOUNCE_OUT,
        S_GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        phase_left;
    logic [3:0]        bounce_n;
    logic [HOLD_W-1:0] hold_len;
    logic [HOLD_W-1:0] cmd_hold_eff;

    // A zero hold still produces one closed cycle.
    assign cmd_hold_eff = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = ~cmd_ready;

    // The switch matrix: the chosen column is pulled low only while the
    // contact is closed and the scanner is driving the key's row. Other
    // rows being low at the same time do not mask it.
    always_comb begin
        col_n = 4'b1111;
        if (key_down && !row_n[active_key[3:2]]) begin
            col_n[active_key[1:0]] = 1'b0;
        end
    end

    // Press sequencer. Each phase loads cnt with (length-1) and advances
    // when it reaches zero. During bounce, phase_left counts the remaining
    // phases and the contact toggles at every phase boundary; the press
    // bounce starts closed and ends open, the release bounce starts open
    // and ends closed, so a single toggle rule serves both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            phase_left <= '0;
            bounce_n   <= '0;
            hold_len   <= '0;
            key_down   <= 1'b0;
            active_key <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state      <= S_IDLE;
                key_down   <= 1'b0;
                cnt        <= '0;
                phase_left <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            active_key <= cmd_key;
                            hold_len   <= cmd_hold_eff;
                            bounce_n   <= cmd_bounce;
                            key_down   <= 1'b1;
                            if (cmd_bounce == 4'd0) begin
                                state <= S_HELD;
                                cnt   <= CNT_W'(cmd_hold_eff - HOLD_W'(1));
                            end else begin
                                state      <= S_BOUNCE_IN;
                                cnt        <= BP_LOAD;
                                phase_left <= {cmd_bounce, 1'b0} - 5'd1;
                            end
                        end
                    end
                    S_BOUNCE_IN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (phase_left != 5'd0) begin
                            phase_left <= phase_left - 5'd1;
                            key_down   <= ~key_down;
                            cnt        <= BP_LOAD;
                        end else begin
                            state    <= S_HELD;
                            key_down <= 1'b1;
                            cnt      <= CNT_W'(hold_len - HOLD_W'(1));
                        end
                    end
                    S_HELD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (bounce_n == 4'd0) begin
                            state    <= S_GAP;
                            key_down <= 1'b0;
                            cnt      <= GAP_LOAD;
                        end else begin
                            state      <= S_BOUNCE_OUT;
                            key_down   <= 1'b0;
                            cnt        <= BP_LOAD;
                            phase_left <= {bounce_n, 1'b0} - 5'd1;
                        end
                    end
                    S_BOUNCE_OUT: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (phase_left != 5'd0) begin
                            phase_left <= phase_left - 5'd1;
                            key_down   <= ~key_down;
                            cnt        <= BP_LOAD;
                        end else begin
                            state    <= S_GAP;
                            key_down <= 1'b0;
                            cnt      <= GAP_LOAD;
                        end
                    end
                    S_GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        key_down <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_emulator
//
// Self-checking bench for keypad_emulator. A reference model turns each
// accepted command into a queue of per-cycle contact values; a compare
// process checks every DUT output against it each cycle. Directed scenarios
// add hand-computed expectations, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_keypad_emulator;

    localparam int BP     = 4;
    localparam int GAP    = 8;
    localparam int HOLD_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        row_n;
    logic [3:0]        col_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;
    logic [3:0]        cmd_bounce;
    logic              abort;
    logic              key_down;
    logic [3:0]        active_key;
    logic              busy;
    logic              done;

    int nChecks = 0;
    int nFails  = 0;

    keypad_emulator #(
        .BOUNCE_PERIOD(BP),
        .GAP_CYCLES(GAP),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_n(row_n),
        .col_n(col_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_key(cmd_key),
        .cmd_hold(cmd_hold),
        .cmd_bounce(cmd_bounce),
        .abort(abort),
        .key_down(key_down),
        .active_key(active_key),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a command becomes the full list of contact values it
    // must produce, one per cycle; done follows once the list runs out.
    bit       mQ[$];
    bit       mBusy = 1'b0;
    bit       mKd   = 1'b0;
    bit       mDone = 1'b0;
    bit [3:0] mKey  = 4'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mQ.delete();
            mBusy = 1'b0;
            mKd   = 1'b0;
            mDone = 1'b0;
            mKey  = 4'd0;
        end else if (mBusy) begin
            mDone = 1'b0;
            if (abort) begin
                mQ.delete();
                mBusy = 1'b0;
                mKd   = 1'b0;
            end else if (mQ.size() > 0) begin
                mKd = mQ.pop_front();
            end else begin
                mBusy = 1'b0;
                mKd   = 1'b0;
                mDone = 1'b1;
            end
        end else begin
            mDone = 1'b0;
            if (cmd_valid) begin
                int h;
                int n;
                h = (cmd_hold == 0) ? 1 : int'(cmd_hold);
                n = int'(cmd_bounce);
                mKey = cmd_key;
                for (int p = 0; p < 2 * n; p++)
                    for (int c = 0; c < BP; c++) mQ.push_back(p % 2 == 0);
                for (int c = 0; c < h; c++) mQ.push_back(1'b1);
                for (int p = 0; p < 2 * n; p++)
                    for (int c = 0; c < BP; c++) mQ.push_back(p % 2 == 1);
                for (int c = 0; c < GAP; c++) mQ.push_back(1'b0);
                mKd   = mQ.pop_front();
                mBusy = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled well after the edge.
    bit cmpEn = 1'b0;

    always @(posedge clk) begin
        #2;
        if (cmpEn) begin
            logic [3:0] expCol;
            expCol = 4'b1111;
            if (mKd && row_n[mKey[3:2]] == 1'b0) expCol[mKey[1:0]] = 1'b0;
            checkOutput("key_down", 64'(key_down), 64'(mKd));
            checkOutput("cmd_ready", 64'(cmd_ready), 64'(!mBusy));
            checkOutput("busy", 64'(busy), 64'(mBusy));
            checkOutput("done", 64'(done), 64'(mDone));
            checkOutput("active_key", 64'(active_key), 64'(mKey));
            checkOutput("col_n", 64'(col_n), 64'(expCol));
        end
    end

    // Trace of outputs for directed scenarios; bit k holds the value in the
    // k-th cycle after the accepting edge (bit 1 = first cycle).
    logic [127:0] kdV;
    logic [127:0] doneV;
    logic [127:0] rdyV;
    int           trIdx   = 0;
    bit           tracing = 1'b0;

    always @(posedge clk) begin
        #2;
        if (tracing && trIdx < 127) begin
            trIdx++;
            kdV[trIdx]   = key_down;
            doneV[trIdx] = done;
            rdyV[trIdx]  = cmd_ready;
        end
    end

    // Bits a..b of a trace, earliest cycle in the LSB.
    function automatic logic [63:0] field(input logic [127:0] v, input int a, input int b);
        logic [127:0] t;
        t = v >> a;
        return t[63:0] & ((64'd1 << (b - a + 1)) - 64'd1);
    endfunction

    task automatic applyStimulus(input logic v, input logic [3:0] k, input logic [HOLD_W-1:0] h,
                                 input logic [3:0] n, input logic ab, input logic [3:0] rows);
        @(negedge clk);
        cmd_valid  = v;
        cmd_key    = k;
        cmd_hold   = h;
        cmd_bounce = n;
        abort      = ab;
        row_n      = rows;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400 && cmd_ready !== 1'b1; i++) @(negedge clk);
        if (cmd_ready !== 1'b1) checkOutput("waitIdle timeout", 64'(cmd_ready), 64'd1);
    endtask

    // Presents one command for a single edge; returns at the negedge of the
    // first cycle after acceptance.
    task automatic issueCmd(input logic [3:0] k, input logic [HOLD_W-1:0] h, input logic [3:0] n);
        waitIdle();
        applyStimulus(1'b1, k, h, n, 1'b0, row_n);
        kdV     = '0;
        doneV   = '0;
        rdyV    = '0;
        trIdx   = 0;
        tracing = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        row_n      = 4'b1111;
        cmd_valid  = 1'b0;
        cmd_key    = 4'd0;
        cmd_hold   = '0;
        cmd_bounce = 4'd0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        cmpEn = 1'b1;
        checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("reset key_down", 64'(key_down), 64'd0);
        checkOutput("reset active_key", 64'(active_key), 64'd0);
        rst_n = 1'b1;

        // Clean press of key 5 with hold 10, answered on row 1.
        row_n = 4'b1101;
        issueCmd(4'd5, 16'd10, 4'd0);
        repeat (19) @(negedge clk);
        checkOutput("t1 key_down trace", field(kdV, 1, 19), 64'h003FF);
        checkOutput("t1 done trace", field(doneV, 1, 19), 64'h40000);
        checkOutput("t1 ready trace", field(rdyV, 1, 19), 64'h40000);

        // Same key with two bounces on each edge.
        issueCmd(4'd5, 16'd10, 4'd2);
        repeat (51) @(negedge clk);
        checkOutput("t2 bounce in", field(kdV, 1, 16), 64'h0F0F);
        checkOutput("t2 held", field(kdV, 17, 26), 64'h3FF);
        checkOutput("t2 bounce out", field(kdV, 27, 42), 64'hF0F0);
        checkOutput("t2 gap", field(kdV, 43, 51), 64'h0);
        checkOutput("t2 done early", field(doneV, 1, 50), 64'h0);
        checkOutput("t2 done at 51", field(doneV, 51, 51), 64'h1);

        // Row sweep while key 5 is held.
        issueCmd(4'd5, 16'd10, 4'd0);
        begin
            logic [3:0] rows [5];
            logic [3:0] cols [5];
            rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100};
            cols = '{4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1101};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                row_n = rows[i];
                #1;
                checkOutput($sformatf("t3 col_n rows=%b", rows[i]), 64'(col_n), 64'(cols[i]));
            end
        end
        issueCmd(4'd15, 16'd3, 4'd0);
        row_n = 4'b0111;
        #1;
        checkOutput("t3 key15 col_n", 64'(col_n), 64'b0111);

        // Abort during the hold, then a fresh command right away.
        issueCmd(4'd5, 16'd10, 4'd0);
        row_n = 4'b1101;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        checkOutput("t4 key_down after abort", 64'(key_down), 64'd0);
        checkOutput("t4 ready after abort", 64'(cmd_ready), 64'd1);
        checkOutput("t4 key held", 64'(active_key), 64'd5);
        abort      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_key    = 4'd3;
        cmd_hold   = 16'd2;
        cmd_bounce = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("t4 new cmd busy", 64'(busy), 64'd1);
        checkOutput("t4 new cmd key", 64'(active_key), 64'd3);
        checkOutput("t4 pre-abort key_down", field(kdV, 1, 5), 64'h1F);
        checkOutput("t4 no done", field(doneV, 1, 7), 64'h0);

        // Reset mid-press during the bounce-in.
        issueCmd(4'd5, 16'd10, 4'd2);
        repeat (11) @(negedge clk);
        checkOutput("t5 key_down before reset", field(kdV, 12, 12), 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        row_n = 4'b0000;
        #1;
        checkOutput("t5 key_down", 64'(key_down), 64'd0);
        checkOutput("t5 ready", 64'(cmd_ready), 64'd1);
        checkOutput("t5 busy", 64'(busy), 64'd0);
        checkOutput("t5 done", 64'(done), 64'd0);
        checkOutput("t5 active_key", 64'(active_key), 64'd0);
        checkOutput("t5 col_n", 64'(col_n), 64'hF);
        rst_n = 1'b1;
        row_n = 4'b1101;

        // Zero hold, with a different command offered while busy.
        issueCmd(4'd5, 16'd0, 4'd0);
        cmd_valid = 1'b1;
        cmd_key   = 4'd9;
        cmd_hold  = 16'd7;
        @(negedge clk);
        checkOutput("t6 key ignored", 64'(active_key), 64'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        waitIdle();
        checkOutput("t6 single closed cycle", field(kdV, 1, 2), 64'b01);
        checkOutput("t6 done at 10", field(doneV, 1, 10), 64'h200);
        tracing = 1'b0;

        // Randomized traffic checked by the per-cycle model compare.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 299) != 0);
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_key    = 4'($urandom_range(0, 15));
            cmd_hold   = 16'($urandom_range(0, 12));
            cmd_bounce = 4'($urandom_range(0, 3));
            abort      = ($urandom_range(0, 99) < 2);
            row_n      = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
